// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU pipeline: operand-forward selects, divide
// sequencer states, ALU classification and pipeline stage indices.
package mips_cpu_pkg;

    localparam int unsigned DIVCNT_W = 8;

    localparam int unsigned STG_PC     = 0;
    localparam int unsigned STG_IF_ID  = 1;
    localparam int unsigned STG_ID_EXE = 2;
    localparam int unsigned STG_EXE_MEM = 3;
    localparam int unsigned STG_MEM_WB = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_enum;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_enum;

    typedef enum logic [2:0] {
        ALU_ARITH  = 3'd0,
        ALU_LOGIC  = 3'd1,
        ALU_SHIFT  = 3'd2,
        ALU_MOVE   = 3'd3,
        ALU_MULDIV = 3'd4,
        ALU_JUMP   = 3'd5
    } alutype_enum;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'd0,
        ALUOP_SUB  = 4'd1,
        ALUOP_AND  = 4'd2,
        ALUOP_OR   = 4'd3,
        ALUOP_XOR  = 4'd4,
        ALUOP_NOR  = 4'd5,
        ALUOP_SLT  = 4'd6,
        ALUOP_SLL  = 4'd7,
        ALUOP_SRL  = 4'd8,
        ALUOP_SRA  = 4'd9,
        ALUOP_MULT = 4'd10,
        ALUOP_DIV  = 4'd11,
        ALUOP_LUI  = 4'd12
    } aluop_enum;

endpackage

// File: rtl/pipe_ctrl_div_sequencer.sv
// Multi-cycle divide sequencer: IDLE -> RUN for DIV_CYCLES cycles -> one-cycle DONE.
module div_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_start,
    output logic                div_busy,
    output logic                div_done,
    output logic [DIVCNT_W-1:0] divcnt
);

    div_state_enum       state_q, state_d;
    logic [DIVCNT_W-1:0] divcnt_q, divcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DIV_IDLE;
            divcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            divcnt_q <= divcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        divcnt_d = divcnt_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (div_start) begin
                    state_d  = DIV_RUN;
                    divcnt_d = DIVCNT_W'(DIV_CYCLES - 1);
                end
            end
            DIV_RUN: begin
                if (divcnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    divcnt_d = divcnt_q - 1'b1;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Busy is asserted in the start cycle itself so the pipeline freezes immediately.
    always_comb begin
        div_busy = (state_q == DIV_RUN) || ((state_q == DIV_IDLE) && div_start);
        div_done = (state_q == DIV_DONE);
    end

    assign divcnt = divcnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: divide freeze, load-use interlock, branch flush
// and operand forwarding selects for the two ID-stage sources.
module pipe_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int unsigned NSTAGE     = 5,
    parameter int unsigned RFAW       = 5,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned DELAY_SLOT = 1
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              rfre1,
    input  logic              rfre2,
    input  logic [RFAW-1:0]   rfra1,
    input  logic [RFAW-1:0]   rfra2,
    input  logic              exe_rfwe,
    input  logic              exe_dm2rf,
    input  logic [RFAW-1:0]   exe_rfwa,
    input  logic              mem_rfwe,
    input  logic [RFAW-1:0]   mem_rfwa,
    input  logic              wb_rfwe,
    input  logic [RFAW-1:0]   wb_rfwa,
    input  logic              div_start,
    input  logic              branch_taken,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output fwd_sel_enum       fwd_sel1,
    output fwd_sel_enum       fwd_sel2,
    output logic              div_busy,
    output logic              div_done
);

    logic [DIVCNT_W-1:0] divcnt_w;
    logic                load_use;

    div_sequencer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk       (cpu_clk_50M),
        .rst_n     (cpu_rst_n),
        .div_start (div_start),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .divcnt    (divcnt_w)
    );

    a_divcnt_range: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        divcnt_w < DIVCNT_W'(DIV_CYCLES));

    always_comb begin
        load_use = exe_rfwe && exe_dm2rf && (exe_rfwa != '0) &&
                   ((rfre1 && (rfra1 == exe_rfwa)) || (rfre2 && (rfra2 == exe_rfwa)));
    end

    // Priority: divide freeze masks the load-use interlock, which masks the branch flush.
    always_comb begin
        stall = '0;
        flush = '0;
        if (div_busy) begin
            stall[STG_EXE_MEM:STG_PC] = '1;
            flush[STG_MEM_WB]         = 1'b1;
        end else if (load_use) begin
            stall[STG_IF_ID:STG_PC] = '1;
            flush[STG_ID_EXE]       = 1'b1;
        end else if (branch_taken && (DELAY_SLOT == 0)) begin
            flush[STG_IF_ID] = 1'b1;
        end
    end

    function automatic fwd_sel_enum fwd_pick(
        input logic            re,
        input logic [RFAW-1:0] ra,
        input logic            x_we,
        input logic            x_ld,
        input logic [RFAW-1:0] x_wa,
        input logic            m_we,
        input logic [RFAW-1:0] m_wa,
        input logic            w_we,
        input logic [RFAW-1:0] w_wa
    );
        fwd_pick = FWD_RF;
        if (re && (ra != '0)) begin
            if (x_we && !x_ld && (x_wa == ra)) begin
                fwd_pick = FWD_EXE;
            end else if (m_we && (m_wa == ra)) begin
                fwd_pick = FWD_MEM;
            end else if (w_we && (w_wa == ra)) begin
                fwd_pick = FWD_WB;
            end
        end
    endfunction

    always_comb begin
        fwd_sel1 = fwd_pick(rfre1, rfra1, exe_rfwe, exe_dm2rf, exe_rfwa,
                            mem_rfwe, mem_rfwa, wb_rfwe, wb_rfwa);
        fwd_sel2 = fwd_pick(rfre2, rfra2, exe_rfwe, exe_dm2rf, exe_rfwa,
                            mem_rfwe, mem_rfwa, wb_rfwe, wb_rfwa);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with DIV_CYCLES=4 and no delay slot.
module tb_pipe_ctrl;
    import mips_cpu_pkg::*;

    localparam int unsigned NSTAGE = 5;
    localparam int unsigned RFAW   = 5;

    logic              clk;
    logic              rst_n;
    logic              rfre1, rfre2;
    logic [RFAW-1:0]   rfra1, rfra2;
    logic              exe_rfwe, exe_dm2rf;
    logic [RFAW-1:0]   exe_rfwa;
    logic              mem_rfwe;
    logic [RFAW-1:0]   mem_rfwa;
    logic              wb_rfwe;
    logic [RFAW-1:0]   wb_rfwa;
    logic              div_start, branch_taken;
    logic [NSTAGE-1:0] stall, flush;
    fwd_sel_enum       fwd_sel1, fwd_sel2;
    logic              div_busy, div_done;

    pipe_ctrl #(
        .NSTAGE     (NSTAGE),
        .RFAW       (RFAW),
        .DIV_CYCLES (4),
        .DELAY_SLOT (0)
    ) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst_n    (rst_n),
        .rfre1        (rfre1),
        .rfre2        (rfre2),
        .rfra1        (rfra1),
        .rfra2        (rfra2),
        .exe_rfwe     (exe_rfwe),
        .exe_dm2rf    (exe_dm2rf),
        .exe_rfwa     (exe_rfwa),
        .mem_rfwe     (mem_rfwe),
        .mem_rfwa     (mem_rfwa),
        .wb_rfwe      (wb_rfwe),
        .wb_rfwa      (wb_rfwa),
        .div_start    (div_start),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .div_busy     (div_busy),
        .div_done     (div_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  st;
        logic [4:0]  fl;
        fwd_sel_enum f1;
        fwd_sel_enum f2;
        logic        bz;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rfre1 = 1'b0; rfre2 = 1'b0; rfra1 = '0; rfra2 = '0;
        exe_rfwe = 1'b0; exe_dm2rf = 1'b0; exe_rfwa = '0;
        mem_rfwe = 1'b0; mem_rfwa = '0; wb_rfwe = 1'b0; wb_rfwa = '0;
        div_start = 1'b0; branch_taken = 1'b0;
    endtask

    // Push the expectation for the cycle just driven, compare at the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [4:0] st, input logic [4:0] fl,
                        input fwd_sel_enum f1, input fwd_sel_enum f2,
                        input logic bz, input logic dn);
        exp_t e;
        exp_t o;
        e.tag = tag; e.st = st; e.fl = fl; e.f1 = f1; e.f2 = f2; e.bz = bz; e.dn = dn;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            check_eq({o.tag, ".stall"},    32'(stall),    32'(o.st));
            check_eq({o.tag, ".flush"},    32'(flush),    32'(o.fl));
            check_eq({o.tag, ".fwd1"},     32'(fwd_sel1), 32'(o.f1));
            check_eq({o.tag, ".fwd2"},     32'(fwd_sel2), 32'(o.f2));
            check_eq({o.tag, ".div_busy"}, 32'(div_busy), 32'(o.bz));
            check_eq({o.tag, ".div_done"}, 32'(div_done), 32'(o.dn));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        step("rst_idle", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        div_start = 1'b1;
        step("rst_start_comb", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        div_start = 1'b0;
        step("rst_held", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("post_rst", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);

        // Load-use interlock
        exe_rfwe = 1'b1; exe_dm2rf = 1'b1; exe_rfwa = 5'd5; rfre1 = 1'b1; rfra1 = 5'd5;
        step("lu_src1", 5'b00011, 5'b00100, FWD_RF, FWD_RF, 1'b0, 1'b0);
        clear_inputs();
        step("lu_release", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        exe_rfwe = 1'b1; exe_dm2rf = 1'b1; exe_rfwa = 5'd5; rfre2 = 1'b0; rfra2 = 5'd5;
        step("lu_src2_off", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rfre2 = 1'b1;
        step("lu_src2_on", 5'b00011, 5'b00100, FWD_RF, FWD_RF, 1'b0, 1'b0);
        exe_rfwa = 5'd0; rfra2 = 5'd0;
        step("lu_r0", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        clear_inputs();

        // Forward priority
        exe_rfwe = 1'b1; exe_rfwa = 5'd7; mem_rfwe = 1'b1; mem_rfwa = 5'd7;
        wb_rfwe = 1'b1; wb_rfwa = 5'd7; rfre2 = 1'b1; rfra2 = 5'd7; rfra1 = 5'd7;
        step("fwd_exe", 5'b00000, 5'b00000, FWD_RF, FWD_EXE, 1'b0, 1'b0);
        exe_rfwe = 1'b0;
        step("fwd_mem", 5'b00000, 5'b00000, FWD_RF, FWD_MEM, 1'b0, 1'b0);
        mem_rfwe = 1'b0;
        step("fwd_wb", 5'b00000, 5'b00000, FWD_RF, FWD_WB, 1'b0, 1'b0);
        rfra2 = 5'd0;
        step("fwd_r0", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        exe_rfwe = 1'b1; exe_dm2rf = 1'b1; mem_rfwe = 1'b1; rfre1 = 1'b1; rfra2 = 5'd3;
        step("fwd_load_skips_exe", 5'b00011, 5'b00100, FWD_MEM, FWD_RF, 1'b0, 1'b0);
        clear_inputs();

        // Branch flush without delay slot, and masked by load-use
        branch_taken = 1'b1;
        step("br_flush", 5'b00000, 5'b00010, FWD_RF, FWD_RF, 1'b0, 1'b0);
        exe_rfwe = 1'b1; exe_dm2rf = 1'b1; exe_rfwa = 5'd9; rfre1 = 1'b1; rfra1 = 5'd9;
        step("br_in_lu", 5'b00011, 5'b00100, FWD_RF, FWD_RF, 1'b0, 1'b0);
        clear_inputs();

        // Divide: 5 busy cycles, done on the 6th, start ignored outside IDLE
        div_start = 1'b1;
        step("div_c1", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        step("div_c2_start_ign", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        div_start = 1'b0;
        exe_rfwe = 1'b1; exe_dm2rf = 1'b1; exe_rfwa = 5'd5; rfre1 = 1'b1; rfra1 = 5'd5;
        branch_taken = 1'b1;
        step("div_c3_overlap", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        clear_inputs();
        step("div_c4", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        step("div_c5", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        div_start = 1'b1;
        step("div_c6_done", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b1);
        div_start = 1'b0; branch_taken = 1'b1;
        step("div_c7_branch", 5'b00000, 5'b00010, FWD_RF, FWD_RF, 1'b0, 1'b0);
        clear_inputs();
        step("div_c8_idle", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);

        // Reset mid-divide at divcnt=2 aborts without a done pulse
        div_start = 1'b1;
        step("abort_start", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        div_start = 1'b0;
        step("abort_cnt3", 5'b01111, 5'b10000, FWD_RF, FWD_RF, 1'b1, 1'b0);
        rst_n = 1'b0;
        step("abort_rst", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            step("abort_no_done", 5'b00000, 5'b00000, FWD_RF, FWD_RF, 1'b0, 1'b0);
        end

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
